// File: rtl/sap_mem_ctrl.sv
// SAP-style RAM with MAR, registered read port and zero-fill sequencer.
// Define SAP_MEM_CTRL_PARITY_EN to store and check an even-parity bit per word.
module sap_mem_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mar_in,
   input  logic              mar_inc,
   input  logic              ram_in,
   input  logic              ram_out,
   input  logic              clear_req,
   input  logic              par_inject,
   input  logic [DATA_W-1:0] bus,
   output logic [ADDR_W-1:0] mar_addr,
   output logic [DATA_W-1:0] bus_out,
   output logic              out_valid,
   output logic              busy,
   output logic              clear_done,
   output logic              parity_err
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] mar;
   logic [ADDR_W-1:0] clr_ptr;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              idle;

   generate
      if (DATA_W >= ADDR_W) begin : g_addr_slice
         assign bus_addr = bus[ADDR_W-1:0];
      end else begin : g_addr_ext
         assign bus_addr = {{(ADDR_W-DATA_W){1'b0}}, bus};
      end
   endgenerate

   assign idle     = (state == IDLE);
   assign busy     = ~idle;
   assign mar_addr = mar;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         mar        <= '0;
         clr_ptr    <= '0;
         bus_out    <= '0;
         out_valid  <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         clear_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (mar_in)
                  mar <= bus_addr;
               else if (mar_inc)
                  mar <= mar + 1'b1;
               if (ram_out) begin
                  bus_out   <= mem[mar];
                  out_valid <= 1'b1;
               end
               if (clear_req) begin
                  state   <= CLEAR;
                  clr_ptr <= '0;
               end
            end
            CLEAR: begin
               clr_ptr <= clr_ptr + 1'b1;
               if (clr_ptr == '1) begin
                  state      <= IDLE;
                  clear_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory is never reset; a reset edge also suppresses any write.
   always_ff @(posedge clock) begin
      if (reset) begin
         if (busy)
            mem[clr_ptr] <= '0;
         else if (ram_in)
            mem[mar] <= bus;
      end
   end

`ifdef SAP_MEM_CTRL_PARITY_EN
   logic par [DEPTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         if (busy)
            par[clr_ptr] <= 1'b0;
         else if (ram_in)
            par[mar] <= (^bus) ^ par_inject;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset)
         parity_err <= 1'b0;
      else
         parity_err <= idle & ram_out & ((^mem[mar]) != par[mar]);
   end
`else
   logic unused_par;
   assign unused_par = par_inject;
   assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_sap_mem_ctrl.sv
// Scoreboard bench for sap_mem_ctrl: reads push expected words, outputs pop them.
module tb_sap_mem_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DEPTH = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          mar_in, mar_inc, ram_in, ram_out, clear_req, par_inject;
   logic [DW-1:0] bus;
   logic [AW-1:0] mar_addr;
   logic [DW-1:0] bus_out;
   logic          out_valid, busy, clear_done, parity_err;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] model_mem [DEPTH];
   logic          model_inj [DEPTH];
   logic [AW-1:0] model_mar;
   logic [DW:0]   exp_q [$];

   sap_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset),
      .mar_in(mar_in), .mar_inc(mar_inc),
      .ram_in(ram_in), .ram_out(ram_out),
      .clear_req(clear_req), .par_inject(par_inject),
      .bus(bus), .mar_addr(mar_addr),
      .bus_out(bus_out), .out_valid(out_valid),
      .busy(busy), .clear_done(clear_done),
      .parity_err(parity_err)
   );

   always #5 clock = ~clock;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic perr_of(logic [AW-1:0] a);
`ifdef SAP_MEM_CTRL_PARITY_EN
      return model_inj[a];
`else
      return 1'b0;
`endif
   endfunction

   task automatic set_mar(logic [AW-1:0] a);
      mar_in = 1'b1;
      bus = DW'(a);
      step();
      mar_in = 1'b0;
      model_mar = a;
   endtask

   task automatic wr(logic [DW-1:0] d, logic inj);
      ram_in = 1'b1;
      bus = d;
      par_inject = inj;
      step();
      ram_in = 1'b0;
      par_inject = 1'b0;
      model_mem[model_mar] = d;
      model_inj[model_mar] = inj;
   endtask

   task automatic pop_chk(string tag);
      logic [DW:0] e;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_data"}, 32'(bus_out), 32'(e[DW-1:0]));
         chk({tag, "_perr"}, 32'(parity_err), 32'(e[DW]));
      end
   endtask

   task automatic rd(string tag, logic inc);
      exp_q.push_back({perr_of(model_mar), model_mem[model_mar]});
      ram_out = 1'b1;
      mar_inc = inc;
      step();
      ram_out = 1'b0;
      mar_inc = 1'b0;
      if (inc) model_mar = model_mar + 1'b1;
      pop_chk(tag);
   endtask

   task automatic fill(logic [DW-1:0] d);
      for (int i = 0; i < DEPTH; i++) begin
         set_mar(AW'(i));
         wr(d, 1'b0);
      end
   endtask

   task automatic read_all(string tag);
      set_mar('0);
      for (int i = 0; i < DEPTH; i++)
         rd($sformatf("%s_%0d", tag, i), 1'b1);
      chk({tag, "_mar_wrap"}, 32'(mar_addr), 32'd0);
   endtask

   initial begin
      int n;
      mar_in = 0; mar_inc = 0; ram_in = 0; ram_out = 0;
      clear_req = 0; par_inject = 0; bus = '0;
      model_mar = '0;
      reset = 1'b0;
      step();
      chk("rst_mar", 32'(mar_addr), 32'd0);
      chk("rst_bus_out", 32'(bus_out), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(clear_done), 32'd0);
      chk("rst_perr", 32'(parity_err), 32'd0);
      reset = 1'b1;

      set_mar(4'h5);
      wr(8'hA7, 1'b0);
      rd("basic", 1'b0);
      chk("basic_mar", 32'(mar_addr), 32'd5);
      step();
      chk("hold_valid", 32'(out_valid), 32'd0);
      chk("hold_data", 32'(bus_out), 32'hA7);

      set_mar(4'hF);
      mar_inc = 1'b1;
      step();
      mar_inc = 1'b0;
      chk("mar_wrap", 32'(mar_addr), 32'd0);
      mar_in = 1'b1; mar_inc = 1'b1; bus = 8'h03;
      step();
      mar_in = 1'b0; mar_inc = 1'b0;
      chk("mar_prio", 32'(mar_addr), 32'd3);

      set_mar(4'h2);
      wr(8'h11, 1'b0);
      exp_q.push_back({perr_of(4'h2), model_mem[2]});
      ram_in = 1'b1; ram_out = 1'b1; bus = 8'h22;
      step();
      ram_in = 1'b0; ram_out = 1'b0;
      model_mem[2] = 8'h22;
      model_inj[2] = 1'b0;
      pop_chk("rbw_old");
      rd("rbw_new", 1'b0);

      fill(8'hFF);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      ram_in = 1'b1; mar_in = 1'b1; mar_inc = 1'b1;
      clear_req = 1'b1; ram_out = 1'b1; bus = 8'h55;
      n = 0;
      while (busy && n < 40) begin
         n++;
         step();
      end
      ram_in = 0; mar_in = 0; mar_inc = 0; clear_req = 0; ram_out = 0;
      chk("clr_busy_cycles", 32'(n), 32'd16);
      chk("clr_done_pulse", 32'(clear_done), 32'd1);
      chk("clr_mar_kept", 32'(mar_addr), 32'd15);
      chk("clr_no_read", 32'(out_valid), 32'd0);
      step();
      chk("clr_done_once", 32'(clear_done), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = '0;
         model_inj[i] = 1'b0;
      end
      read_all("clr_rd");

      fill(8'hFF);
      set_mar(4'hF);
      exp_q.push_back({perr_of(4'hF), model_mem[15]});
      clear_req = 1'b1; ram_out = 1'b1;
      step();
      clear_req = 1'b0; ram_out = 1'b0;
      pop_chk("clr_with_read");
      chk("abort_busy_start", 32'(busy), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("abort_busy_run", 32'(busy), 32'd1);
      end
      reset = 1'b0;
      step();
      reset = 1'b1;
      model_mar = '0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(clear_done), 32'd0);
      chk("abort_mar", 32'(mar_addr), 32'd0);
      step();
      chk("abort_done_later", 32'(clear_done), 32'd0);
      for (int i = 0; i < 5; i++) begin
         model_mem[i] = '0;
         model_inj[i] = 1'b0;
      end
      read_all("abort_rd");

      set_mar(4'h3);
      wr(8'h3C, 1'b1);
      rd("par_inj", 1'b0);
      wr(8'h3C, 1'b0);
      rd("par_ok", 1'b0);
      set_mar(4'h4);
      wr(8'h01, 1'b0);
      rd("par_odd_ok", 1'b0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sap_mem_ctrl.md
SAP_MEM_CTRL -- requirements
Module: sap_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: word and bus width, SHALL be >= 2.
REQ-002 Parameter ADDR_W, default 4: MAR width; depth DEPTH = 2**ADDR_W, SHALL be 2..8.
REQ-003 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 mar_in  in  1  load MAR from bus[ADDR_W-1:0].
REQ-006 mar_inc  in  1  increment MAR.
REQ-007 ram_in  in  1  write bus to mem[mar_addr].
REQ-008 ram_out  in  1  read mem[mar_addr] to bus_out.
REQ-009 clear_req  in  1  start zero-fill of the whole memory.
REQ-010 par_inject  in  1  invert stored parity on this write (test only).
REQ-011 bus  in  DATA_W  data/address from the system bus.
REQ-012 mar_addr  out  ADDR_W  current MAR value.
REQ-013 bus_out  out  DATA_W  registered read data.
REQ-014 out_valid  out  1  one-cycle pulse: bus_out updated this cycle.
REQ-015 busy  out  1  clear sequence in progress.
REQ-016 clear_done  out  1  one-cycle pulse at clear completion.
REQ-017 parity_err  out  1  parity mismatch on the word in bus_out, qualified by out_valid.

Function
REQ-018 MAR: mar_in SHALL have priority over mar_inc; mar_inc at DEPTH-1 SHALL wrap to 0.
REQ-019 Write: ram_in SHALL write bus into mem at the MAR value before that edge's MAR update.
REQ-020 Read: ram_out SHALL load bus_out with mem[pre-update MAR] at that edge; out_valid SHALL be 1 for exactly the following cycle; latency 1.
REQ-021 Simultaneous ram_in and ram_out SHALL return the old word (read-before-write).
REQ-022 bus_out SHALL hold its value when no read occurs.
REQ-023 FSM states: IDLE, CLEAR. IDLE->CLEAR on clear_req; CLEAR->IDLE after writing location DEPTH-1.
REQ-024 CLEAR SHALL write zero (correct parity) to one location per cycle, ascending from 0; total DEPTH cycles with busy=1.
REQ-025 clear_done SHALL pulse for one cycle on the CLEAR->IDLE transition; busy SHALL be 0 in that cycle.
REQ-026 While busy, mar_in, mar_inc, ram_in, ram_out and clear_req SHALL be ignored; MAR SHALL be unchanged by CLEAR.
REQ-027 clear_req with ram_in/ram_out in IDLE: the access SHALL complete on that edge, then CLEAR starts.

Reset
REQ-028 When reset=0 at a rising edge: mar_addr=0, bus_out=0, out_valid=0, busy=0, clear_done=0, parity_err=0, FSM=IDLE.
REQ-029 Reset SHALL NOT alter memory contents; reset mid-CLEAR SHALL abort it, leaving a partially cleared memory and no clear_done pulse.

Configuration
REQ-030 Macro SAP_MEM_CTRL_PARITY_EN defined: each word SHALL store an even-parity bit; par_inject=1 SHALL store its inverse; a read SHALL set parity_err=1 with out_valid when stored parity mismatches data.
REQ-031 Macro undefined: no parity storage; parity_err SHALL be constant 0; par_inject ignored; all ports SHALL remain present.

Verification
REQ-032 reset=0 1 cycle; mar_in, bus=0x05; ram_in, bus=0xA7; ram_out -> next cycle bus_out=0xA7, out_valid=1 for one cycle, mar_addr=5.
REQ-033 ADDR_W=4: mar_in bus=0x0F, mar_inc -> mar_addr=0; mar_in+mar_inc same edge with bus=0x03 -> mar_addr=3.
REQ-034 mem[2]=0x11; ram_in bus=0x22 with ram_out at addr 2 -> bus_out=0x11; next read -> 0x22.
REQ-035 Fill all 16 words with 0xFF; clear_req -> busy=1 for 16 cycles, clear_done pulse, all reads return 0x00; ram_in during busy has no effect.
REQ-036 clear_req, reset=0 after 5 cycles -> busy=0, no clear_done; locations 0-4 read 0x00, 5-15 read 0xFF.
REQ-037 SAP_MEM_CTRL_PARITY_EN defined: write 0x3C with par_inject=1, read -> parity_err=1; write 0x3C normally, read -> parity_err=0; macro undefined -> parity_err=0 in both.
